// File: rtl/demux_1_to_n.sv
// -----------------------------------------------------------------------------
// demux_1_to_n
//
// Registered 1-to-N demultiplexer with valid/ready handshakes. A single input
// word stream is steered into one of NUM_OUT output channels. Each channel
// owns a one-entry holding register, so a stalled consumer blocks only the
// words addressed to its own channel.
//
// Handshake semantics (input and every output channel): a transfer happens
// on a rising edge where valid && ready are both high. in_ready is
// combinational from in_sel, out_ready and the channel state. It never
// depends on in_valid. The upstream source keeps in_valid, in_sel and in_data
// stable while it is stalled.
//
// Parameters:
//   WIDTH    data width in bits
//   NUM_OUT  number of output channels, 2..2**SEL_W
//   SEL_W    width of the channel select
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   input word present
//   in_ready   block accepts the input word this cycle
//   in_sel     destination channel index
//   in_data    input word
//   out_valid  bit k: channel k holds a word
//   out_ready  bit k: consumer k takes the word this cycle
//   out_data   channel k word in bits [k*WIDTH +: WIDTH]
//   drop       one-cycle pulse after an out-of-range select was accepted
//   out_count  (DEMUX_COUNT_EN only) 8-bit wrapping output-transfer counter
//              per channel, channel k in bits [k*8 +: 8]
//
// Build option:
//   DEMUX_COUNT_EN  adds out_count and the per-channel counters.
// -----------------------------------------------------------------------------
module demux_1_to_n #(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SEL_W-1:0]           in_sel,
    input  logic [WIDTH-1:0]           in_data,
    output logic [NUM_OUT-1:0]         out_valid,
    input  logic [NUM_OUT-1:0]         out_ready,
    output logic [NUM_OUT*WIDTH-1:0]   out_data,
    output logic                       drop
`ifdef DEMUX_COUNT_EN
    ,
    output logic [NUM_OUT*8-1:0]       out_count
`endif
);

    // Number of addressable select values; may exceed NUM_OUT.
    localparam int NSEL = 1 << SEL_W;
    localparam logic [SEL_W:0] NUM_OUT_W = (SEL_W+1)'(NUM_OUT);

    logic [NUM_OUT-1:0]       full_q, full_d;
    logic [NUM_OUT*WIDTH-1:0] data_q, data_d;
    logic                     drop_q, drop_d;

    // Channel state padded to every select value so in_sel can index it
    // directly, even when it points past the last real channel.
    logic [NSEL-1:0]          full_ext;
    logic [NSEL-1:0]          ready_ext;

    logic                     sel_in_range;
    logic                     in_xfer;
    logic [NUM_OUT-1:0]       load;
    logic [NUM_OUT-1:0]       out_xfer;

    assign sel_in_range = ({1'b0, in_sel} < NUM_OUT_W);

    always_comb begin
        full_ext                = '0;
        ready_ext               = '0;
        full_ext[NUM_OUT-1:0]   = full_q;
        ready_ext[NUM_OUT-1:0]  = out_ready;
    end

    // A full channel can still accept when its consumer drains in the same
    // edge. Out-of-range words are always accepted so they can be discarded.
    always_comb begin
        if (sel_in_range) begin
            in_ready = !full_ext[in_sel] || ready_ext[in_sel];
        end else begin
            in_ready = 1'b1;
        end
    end

    assign in_xfer = in_valid && in_ready;

    always_comb begin
        full_d   = full_q;
        data_d   = data_q;
        load     = '0;
        out_xfer = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            out_xfer[k] = full_q[k] && out_ready[k];
            load[k]     = in_xfer && sel_in_range && (in_sel == SEL_W'(k));
            // A load wins over a drain, so drain+reload keeps the channel full.
            full_d[k]   = load[k] || (full_q[k] && !out_xfer[k]);
            if (load[k]) begin
                data_d[k*WIDTH +: WIDTH] = in_data;
            end
        end
        drop_d = in_xfer && !sel_in_range;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= '0;
            data_q <= '0;
            drop_q <= 1'b0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            drop_q <= drop_d;
        end
    end

    assign out_valid = full_q;
    assign out_data  = data_q;
    assign drop      = drop_q;

`ifdef DEMUX_COUNT_EN
    logic [NUM_OUT*8-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        for (int k = 0; k < NUM_OUT; k++) begin
            count_d[k*8 +: 8] = count_q[k*8 +: 8] + {7'b0, out_xfer[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;
`endif

endmodule

// File: tb/tb_demux_1_to_n.sv
// Testbench for demux_1_to_n. Two instances share the input stream: one with
// four channels (every select in range) and one with three channels (select 3
// is out of range). A behavioural model tracks per-channel occupancy and
// contents, and a per-channel expected queue checks delivery order.
module tb_demux_1_to_n;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid;
  logic [1:0]  in_sel;
  logic [7:0]  in_data;
  logic [3:0]  out_ready;

  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic        drop;

  logic        in_ready3;
  logic [2:0]  out_valid3;
  logic [23:0] out_data3;
  logic        drop3;

`ifdef DEMUX_COUNT_EN
  logic [31:0] out_count;
  logic [23:0] out_count3;
`endif

  demux_1_to_n #(.WIDTH(8), .NUM_OUT(4), .SEL_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop      (drop)
`ifdef DEMUX_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  demux_1_to_n #(.WIDTH(8), .NUM_OUT(3), .SEL_W(2)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready3),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid3),
    .out_ready (out_ready[2:0]),
    .out_data  (out_data3),
    .drop      (drop3)
`ifdef DEMUX_COUNT_EN
    ,
    .out_count (out_count3)
`endif
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Model index 0: four-channel instance, index 1: three-channel instance.
  int         nout [2] = '{4, 3};
  bit         m_full [2][4];
  logic [7:0] m_data [2][4];
  bit         m_drop [2];
  logic [7:0] m_cnt  [2][4];
  logic [7:0] exp_q  [4][$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_ready(input int i);
    int s;
    s = int'(in_sel);
    if (s >= nout[i]) return 1'b1;
    return !m_full[i][s] || out_ready[s];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_drop[i] = 0;
      for (int k = 0; k < 4; k++) begin
        m_full[i][k] = 0;
        m_data[i][k] = 8'h00;
        m_cnt[i][k]  = 8'h00;
      end
    end
    for (int k = 0; k < 4; k++) exp_q[k].delete();
  endtask

  task automatic check_outputs();
    logic [3:0]  ev;
    logic [31:0] ed;
    logic [2:0]  ev3;
    logic [23:0] ed3;
    for (int k = 0; k < 4; k++) begin
      ev[k]          = m_full[0][k];
      ed[k*8 +: 8]   = m_data[0][k];
    end
    for (int k = 0; k < 3; k++) begin
      ev3[k]         = m_full[1][k];
      ed3[k*8 +: 8]  = m_data[1][k];
    end
    check("out_valid", 64'(out_valid), 64'(ev));
    check("out_data", 64'(out_data), 64'(ed));
    check("drop", 64'(drop), 64'(m_drop[0]));
    check("out_valid3", 64'(out_valid3), 64'(ev3));
    check("out_data3", 64'(out_data3), 64'(ed3));
    check("drop3", 64'(drop3), 64'(m_drop[1]));
`ifdef DEMUX_COUNT_EN
    for (int k = 0; k < 4; k++) check("out_count", 64'(out_count[k*8 +: 8]), 64'(m_cnt[0][k]));
    for (int k = 0; k < 3; k++) check("out_count3", 64'(out_count3[k*8 +: 8]), 64'(m_cnt[1][k]));
`endif
  endtask

  // One clock: check handshake mid-cycle, advance model, check outputs after edge.
  task automatic step();
    logic [7:0] d;
    @(negedge clk);
    if (!reset) begin
      check("in_ready", 64'(in_ready), 64'(exp_ready(0)));
      check("in_ready3", 64'(in_ready3), 64'(exp_ready(1)));
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          check("sb_nonempty", 64'(exp_q[k].size() > 0), 64'd1);
          if (exp_q[k].size() > 0) begin
            d = exp_q[k].pop_front();
            check("sb_order", 64'(out_data[k*8 +: 8]), 64'(d));
          end
        end
      end
    end
    if (reset) begin
      model_clear();
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit acc;
        int s;
        acc = in_valid && exp_ready(i);
        s   = int'(in_sel);
        m_drop[i] = acc && (s >= nout[i]);
        for (int k = 0; k < nout[i]; k++) begin
          bit ox;
          ox = m_full[i][k] && out_ready[k];
          if (ox) m_cnt[i][k] = m_cnt[i][k] + 8'd1;
          if (acc && s == k) begin
            m_full[i][k] = 1;
            m_data[i][k] = in_data;
            if (i == 0) exp_q[k].push_back(in_data);
          end else if (ox) begin
            m_full[i][k] = 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // ---------------- driver / tests ----------------
  initial begin
    logic [2:0] prev_v3;
    int ch;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = 8'hA5;
    out_ready = 4'b0000;
    model_clear();

    // Reset with a word presented: it must be ignored.
    step();
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_drop", 64'(drop), 64'd0);
    step();

    // Single route to channel 2, then a blocked second word.
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h3C;
    step();
    in_valid = 1'b0;
    check("route_valid", 64'(out_valid), 64'h4);
    check("route_data", 64'(out_data[23:16]), 64'h3C);
    in_valid = 1'b1; in_data = 8'h77;
    #1;
    check("full_block", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    out_ready = 4'b0100;
    step();
    check("route_drain", 64'(out_valid), 64'h0);
    check("route_hold", 64'(out_data[23:16]), 64'h3C);

    // Backpressure isolation between channels 0 and 1.
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h22;
    step();
    in_sel = 2'd1; in_data = 8'h11;
    #1;
    check("iso_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("iso_valid", 64'(out_valid), 64'h3);
    out_ready = 4'b0001;
    step();
    check("iso_drain", 64'(out_valid), 64'h2);
    out_ready = 4'b1111;
    step();

    // Streaming alternating channels 0 and 3.
    for (int i = 0; i < 16; i++) begin
      ch = (i % 2 == 1) ? 3 : 0;
      in_valid = 1'b1; in_sel = 2'(ch); in_data = 8'(i);
      #1;
      check("stream_ready", 64'(in_ready), 64'd1);
      step();
      check("stream_data", 64'(out_data[ch*8 +: 8]), 64'(i));
      check("stream_valid", 64'(out_valid[ch]), 64'd1);
    end
    in_valid = 1'b0;
    step();

    // Out-of-range select on the three-channel instance.
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h5A;
    step();
    in_sel = 2'd3; in_data = 8'hFF;
    #1;
    check("drop_ready", 64'(in_ready3), 64'd1);
    prev_v3 = out_valid3;
    step();
    in_valid = 1'b0;
    check("drop_pulse", 64'(drop3), 64'd1);
    check("drop_state", 64'(out_valid3), 64'(prev_v3));
    step();
    check("drop_end", 64'(drop3), 64'd0);

    // Randomised traffic.
    for (int c = 0; c < 2000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 8'($urandom);
      out_ready = 4'($urandom_range(0, 15));
      step();
    end
    in_valid = 1'b0;

`ifdef DEMUX_COUNT_EN
    // Counter wrap: 257 output transfers on channel 1.
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 4'b0010;
    in_valid = 1'b1; in_sel = 2'd1;
    for (int i = 0; i < 257; i++) begin
      in_data = 8'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    check("cnt_ch1", 64'(out_count[15:8]), 64'd1);
    check("cnt_others", 64'({out_count[31:16], out_count[7:0]}), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
